// File: rtl/deadlock_block_aggregator.sv
// deadlock_block_aggregator: confirms a deadlock when monitors stay blocked without progress for TIMEOUT cycles
//   clock, reset (async, active-low)
//   enable        detection enable
//   block_sigs    per-monitor block flags
//   progress      top-level handshake pulse, cancels the watch
//   clear         synchronous clear of a sticky report
//   deadlock      sticky deadlock flag
//   deadlock_idx  lowest-index monitor in deadlock_mask
//   deadlock_mask monitors continuously blocked over the whole window
//   watching      high while a window is being timed
module deadlock_block_aggregator #(
  parameter int N_MON   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_MON-1:0] block_sigs,
  input  logic             progress,
  input  logic             clear,
  output logic             deadlock,
  output logic [IDX_W-1:0] deadlock_idx,
  output logic [N_MON-1:0] deadlock_mask,
  output logic             watching
);
  typedef enum logic [1:0] {IDLE, WATCH, REPORTED} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_MON-1:0] mask_q, mask_d, dmask_d;
  logic [IDX_W-1:0] didx_d;
  logic dl_d, cond;
  logic [N_MON-1:0] live;
  function automatic logic [IDX_W-1:0] low_idx(input logic [N_MON-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_MON - 1; i >= 0; i--)
      if (v[i]) r = IDX_W'(i);
    return r;
  endfunction
  assign cond = enable & (|block_sigs) & ~progress;
  assign live = mask_q & block_sigs;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    dl_d    = deadlock;
    dmask_d = deadlock_mask;
    didx_d  = deadlock_idx;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      mask_d  = '0;
      dl_d    = 1'b0;
      dmask_d = '0;
      didx_d  = '0;
    end else if (state_q == IDLE) begin
      if (cond && TIMEOUT == 1) begin
        state_d = REPORTED;
        dl_d    = 1'b1;
        dmask_d = block_sigs;
        didx_d  = low_idx(block_sigs);
      end else if (cond) begin
        state_d = WATCH;
        cnt_d   = CNT_W'(1);
        mask_d  = block_sigs;
      end
    end else if (state_q == WATCH) begin
      if (!cond) begin
        state_d = IDLE;
        cnt_d   = '0;
        mask_d  = '0;
      end else if (live == '0) begin
        // a different set of monitors is blocked: restart the window on it
        cnt_d  = CNT_W'(1);
        mask_d = block_sigs;
      end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d = REPORTED;
        dl_d    = 1'b1;
        dmask_d = live;
        didx_d  = low_idx(live);
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        mask_d = live;
      end
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mask_q        <= '0;
      deadlock      <= 1'b0;
      deadlock_mask <= '0;
      deadlock_idx  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      deadlock      <= dl_d;
      deadlock_mask <= dmask_d;
      deadlock_idx  <= didx_d;
    end
  end
  assign watching = (state_q == WATCH);
endmodule

// File: tb/tb_deadlock_block_aggregator.sv
// tb_deadlock_block_aggregator: directed self-checking bench for deadlock_block_aggregator
module tb_deadlock_block_aggregator;
  logic clock = 1'b0;
  logic reset, enable, progress, clear;
  logic [3:0] block_sigs;
  logic deadlock, watching;
  logic [1:0] deadlock_idx;
  logic [3:0] deadlock_mask;
  int checks = 0;
  int errors = 0;

  deadlock_block_aggregator #(.N_MON(4), .TIMEOUT(4), .CNT_W(16), .IDX_W(2)) dut (
    .clock(clock), .reset(reset), .enable(enable), .block_sigs(block_sigs),
    .progress(progress), .clear(clear), .deadlock(deadlock),
    .deadlock_idx(deadlock_idx), .deadlock_mask(deadlock_mask), .watching(watching)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    block_sigs = 4'b0000;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; progress = 1'b0; clear = 1'b0; block_sigs = 4'b0000;
    #3;
    checks++;
    if ({deadlock, deadlock_idx, deadlock_mask, watching} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got dl=%b idx=%0d mask=%b w=%b, want all 0", deadlock, deadlock_idx, deadlock_mask, watching);
    end
    #9 reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    enable = 1'b1;
    block_sigs = 4'b0100;
    step();
    checks++;
    if (watching !== 1'b1 || deadlock !== 1'b0) begin
      errors++;
      $display("FAIL basic_edge1: got w=%b dl=%b, want w=1 dl=0", watching, deadlock);
    end
    step();
    step();
    checks++;
    if (deadlock !== 1'b0) begin
      errors++;
      $display("FAIL basic_edge3: got dl=%b, want 0", deadlock);
    end
    step();
    checks++;
    if (deadlock !== 1'b1 || deadlock_mask !== 4'b0100 || deadlock_idx !== 2'd2 || watching !== 1'b0) begin
      errors++;
      $display("FAIL basic_edge4: got dl=%b mask=%b idx=%0d w=%b, want dl=1 mask=0100 idx=2 w=0", deadlock, deadlock_mask, deadlock_idx, watching);
    end
  endtask

  task automatic test_reported_hold();
    block_sigs = 4'b0000;
    progress = 1'b1;
    enable = 1'b0;
    step();
    progress = 1'b0;
    step();
    checks++;
    if (deadlock !== 1'b1 || deadlock_mask !== 4'b0100 || deadlock_idx !== 2'd2) begin
      errors++;
      $display("FAIL reported_hold: got dl=%b mask=%b idx=%0d, want dl=1 mask=0100 idx=2", deadlock, deadlock_mask, deadlock_idx);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (deadlock !== 1'b0 || deadlock_mask !== 4'b0000 || deadlock_idx !== 2'd0 || watching !== 1'b0) begin
      errors++;
      $display("FAIL clear_report: got dl=%b mask=%b idx=%0d w=%b, want all 0", deadlock, deadlock_mask, deadlock_idx, watching);
    end
    enable = 1'b1;
  endtask

  task automatic test_progress();
    block_sigs = 4'b0001;
    progress = 1'b1;
    step();
    checks++;
    if (watching !== 1'b0) begin
      errors++;
      $display("FAIL progress_same_edge: got w=%b, want 0", watching);
    end
    block_sigs = 4'b0010;
    progress = 1'b0;
    step();
    step();
    progress = 1'b1;
    step();
    progress = 1'b0;
    checks++;
    if (watching !== 1'b0 || deadlock !== 1'b0) begin
      errors++;
      $display("FAIL progress_cancel: got w=%b dl=%b, want w=0 dl=0", watching, deadlock);
    end
    for (int i = 1; i <= 3; i++) step();
    checks++;
    if (deadlock !== 1'b0 || watching !== 1'b1) begin
      errors++;
      $display("FAIL reblock_edge3: got dl=%b w=%b, want dl=0 w=1", deadlock, watching);
    end
    step();
    checks++;
    if (deadlock !== 1'b1 || deadlock_idx !== 2'd1 || deadlock_mask !== 4'b0010) begin
      errors++;
      $display("FAIL reblock_edge4: got dl=%b mask=%b idx=%0d, want dl=1 mask=0010 idx=1", deadlock, deadlock_mask, deadlock_idx);
    end
    do_clear();
  endtask

  task automatic test_restart();
    block_sigs = 4'b0001;
    step();
    step();
    block_sigs = 4'b1000;
    for (int i = 1; i <= 3; i++) step();
    checks++;
    if (deadlock !== 1'b0 || watching !== 1'b1) begin
      errors++;
      $display("FAIL restart_edge3: got dl=%b w=%b, want dl=0 w=1", deadlock, watching);
    end
    step();
    checks++;
    if (deadlock !== 1'b1 || deadlock_mask !== 4'b1000 || deadlock_idx !== 2'd3) begin
      errors++;
      $display("FAIL restart_edge4: got dl=%b mask=%b idx=%0d, want dl=1 mask=1000 idx=3", deadlock, deadlock_mask, deadlock_idx);
    end
    do_clear();
  endtask

  task automatic test_narrow();
    block_sigs = 4'b0110;
    step();
    step();
    block_sigs = 4'b0100;
    step();
    checks++;
    if (deadlock !== 1'b0) begin
      errors++;
      $display("FAIL narrow_edge3: got dl=%b, want 0", deadlock);
    end
    step();
    checks++;
    if (deadlock !== 1'b1 || deadlock_mask !== 4'b0100 || deadlock_idx !== 2'd2) begin
      errors++;
      $display("FAIL narrow_edge4: got dl=%b mask=%b idx=%0d, want dl=1 mask=0100 idx=2", deadlock, deadlock_mask, deadlock_idx);
    end
    do_clear();
  endtask

  task automatic test_async_reset();
    block_sigs = 4'b0100;
    step();
    step();
    checks++;
    if (watching !== 1'b1 || dut.cnt_q !== 16'd2) begin
      errors++;
      $display("FAIL pre_reset_watch: got w=%b cnt=%0d, want w=1 cnt=2", watching, dut.cnt_q);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (watching !== 1'b0 || dut.cnt_q !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got w=%b cnt=%0d, want w=0 cnt=0", watching, dut.cnt_q);
    end
    #2 reset = 1'b1;
    for (int i = 1; i <= 3; i++) step();
    checks++;
    if (deadlock !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_edge3: got dl=%b, want 0", deadlock);
    end
    step();
    checks++;
    if (deadlock !== 1'b1 || deadlock_idx !== 2'd2) begin
      errors++;
      $display("FAIL post_reset_edge4: got dl=%b idx=%0d, want dl=1 idx=2", deadlock, deadlock_idx);
    end
    do_clear();
  endtask

  task automatic test_enable_low();
    enable = 1'b0;
    block_sigs = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (deadlock !== 1'b0 || watching !== 1'b0) begin
        errors++;
        $display("FAIL enable_low_cycle%0d: got dl=%b w=%b, want 0 0", i, deadlock, watching);
      end
    end
    enable = 1'b1;
    step();
    step();
    enable = 1'b0;
    step();
    checks++;
    if (watching !== 1'b0) begin
      errors++;
      $display("FAIL enable_drop: got w=%b, want 0", watching);
    end
    do_clear();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reported_hold();
    test_progress();
    test_restart();
    test_narrow();
    test_async_reset();
    test_enable_low();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
